// File: rtl/updown_ctr_cfg_sequencer.sv
// Two-requester job sequencer for the 8-bit up/down counter: arbitrates, range-checks,
// programs PLR/ULR/LLR/CCR, pulses start and reports how the run ended.
module updown_ctr_cfg_sequencer #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMO_W       = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_cfg0,
  input  logic [31:0] req_cfg1,
  output logic [1:0]  req_ack,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [1:0]  status,
  output logic        ctr_ncs,
  output logic        ctr_nwr,
  output logic        ctr_nrd,
  output logic [1:0]  ctr_a,
  output logic [7:0]  ctr_dout,
  output logic        ctr_start,
  input  logic        ctr_ec,
  input  logic        ctr_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_WR_PLR, S_WR_ULR, S_WR_LLR, S_WR_CCR, S_GAP, S_START, S_RUN, S_DONE
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_REJ = 2'b11;

  state_t             state_reg, state_next;
  logic [31:0]        cfg_reg;
  logic               id_reg;
  logic               last_grant_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;

  logic               grant_id;
  logic [1:0]         job_status_next;
  logic               cfg_bad;

  logic [1:0]         req_ack_next;
  logic               ctr_ncs_next, ctr_nwr_next, ctr_start_next;
  logic [1:0]         ctr_a_next;
  logic [7:0]         ctr_dout_next;

  logic [7:0] plr, ulr, llr, ccr;
  assign plr = cfg_reg[31:24];
  assign ulr = cfg_reg[23:16];
  assign llr = cfg_reg[15:8];
  assign ccr = cfg_reg[7:0];
  assign cfg_bad = (plr < llr) || (plr > ulr) || (ccr == 8'd0);

  // Round-robin only matters when both requesters are waiting
  always_comb begin
    if (req_valid == 2'b11) grant_id = ~last_grant_reg;
    else                    grant_id = req_valid[1];
  end

  always_comb begin
    state_next      = state_reg;
    job_status_next = ST_OK;
    case (state_reg)
      S_IDLE:   if (|req_valid) state_next = S_CHK;
      S_CHK: begin
        if (cfg_bad) begin
          state_next      = S_DONE;
          job_status_next = ST_REJ;
        end else begin
          state_next = S_WR_PLR;
        end
      end
      S_WR_PLR: state_next = S_WR_ULR;
      S_WR_ULR: state_next = S_WR_LLR;
      S_WR_LLR: state_next = S_WR_CCR;
      S_WR_CCR: state_next = S_GAP;
      S_GAP:    state_next = S_START;
      S_START:  state_next = S_RUN;
      S_RUN: begin
        if (ctr_err) begin
          state_next      = S_DONE;
          job_status_next = ST_ERR;
        end else if (ctr_ec) begin
          state_next      = S_DONE;
          job_status_next = ST_OK;
        end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_next      = S_DONE;
          job_status_next = ST_TMO;
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it
  always_comb begin
    req_ack_next   = 2'b00;
    ctr_ncs_next   = 1'b1;
    ctr_nwr_next   = 1'b1;
    ctr_start_next = 1'b0;
    ctr_a_next     = 2'b00;
    ctr_dout_next  = 8'd0;
    if (state_reg == S_IDLE && state_next == S_CHK)
      req_ack_next = grant_id ? 2'b10 : 2'b01;
    case (state_next)
      S_WR_PLR: begin ctr_ncs_next = 1'b0; ctr_nwr_next = 1'b0; ctr_a_next = 2'b00; ctr_dout_next = plr; end
      S_WR_ULR: begin ctr_ncs_next = 1'b0; ctr_nwr_next = 1'b0; ctr_a_next = 2'b01; ctr_dout_next = ulr; end
      S_WR_LLR: begin ctr_ncs_next = 1'b0; ctr_nwr_next = 1'b0; ctr_a_next = 2'b10; ctr_dout_next = llr; end
      S_WR_CCR: begin ctr_ncs_next = 1'b0; ctr_nwr_next = 1'b0; ctr_a_next = 2'b11; ctr_dout_next = ccr; end
      S_GAP:    ctr_ncs_next = 1'b0;
      S_START:  begin ctr_ncs_next = 1'b0; ctr_start_next = 1'b1; end
      S_RUN:    ctr_ncs_next = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cfg_reg        <= 32'd0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      tmo_cnt_reg    <= '0;
      req_ack        <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      done_id        <= 1'b0;
      status         <= 2'b00;
      ctr_ncs        <= 1'b1;
      ctr_nwr        <= 1'b1;
      ctr_nrd        <= 1'b1;
      ctr_a          <= 2'b00;
      ctr_dout       <= 8'd0;
      ctr_start      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && state_next == S_CHK) begin
        cfg_reg        <= grant_id ? req_cfg1 : req_cfg0;
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      // Counter is held at zero outside RUN, so it starts from zero on RUN entry
      if (state_reg == S_RUN) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      else                    tmo_cnt_reg <= '0;
      req_ack   <= req_ack_next;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      if (state_next == S_DONE) begin
        done_id <= id_reg;
        status  <= job_status_next;
      end
      ctr_ncs   <= ctr_ncs_next;
      ctr_nwr   <= ctr_nwr_next;
      ctr_nrd   <= 1'b1;
      ctr_a     <= ctr_a_next;
      ctr_dout  <= ctr_dout_next;
      ctr_start <= ctr_start_next;
    end
  end

endmodule
